// File: rtl/alu_secuencial.sv
// Sequential ALU: registered result/flags, valid/ready input handshake,
// shift-add multiply and restoring unsigned divide/remainder.
module alu_secuencial #(
   parameter int NUM_BITS = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [NUM_BITS-1:0] A,
   input  logic [NUM_BITS-1:0] B,
   input  logic [3:0]          S,
   output logic [NUM_BITS-1:0] R,
   output logic                N,
   output logic                Z,
   output logic                C,
   output logic                V,
   output logic                done
);

   localparam int SW  = $clog2(NUM_BITS);
   localparam int MSB = NUM_BITS - 1;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_MUL  = 4'b0010;
   localparam logic [3:0] OP_DIVU = 4'b0011;
   localparam logic [3:0] OP_REMU = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_XOR  = 4'b1010;
   localparam logic [3:0] OP_SHL  = 4'b1011;
   localparam logic [3:0] OP_SHR  = 4'b1100;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t              state_q, state_d;
   logic [NUM_BITS-1:0] a_q, b_q, hi_q, lo_q;
   logic [3:0]          s_q;
   logic [SW-1:0]       cnt_q;

   logic                iter_op, last, is_mul, div_by0;
   logic                load, c_d, v_d;
   logic [NUM_BITS-1:0] res_d;

   logic [NUM_BITS:0]   add_w, sub_w;
   logic [SW-1:0]       shamt;
   logic [NUM_BITS-1:0] alu_r;
   logic                alu_c, alu_v;

   logic [NUM_BITS:0]   mul_sum;
   logic [NUM_BITS-1:0] mul_hi_nx, mul_lo_nx;
   logic [NUM_BITS:0]   div_sh;
   logic                div_ge;
   logic [NUM_BITS-1:0] div_sub, div_r_nx, div_q_nx;

   assign in_ready = (state_q == IDLE);
   assign done     = (state_q == DONE);

   assign iter_op = (S == OP_MUL) || (S == OP_DIVU) || (S == OP_REMU);
   assign last    = (cnt_q == SW'(NUM_BITS - 1));
   assign is_mul  = (s_q == OP_MUL);
   assign div_by0 = (b_q == '0);

   // Single-cycle ops work on A/B directly: the result is registered on the accept edge.
   assign add_w = {1'b0, A} + {1'b0, B};
   assign sub_w = {1'b0, A} + {1'b0, ~B} + {{NUM_BITS{1'b0}}, 1'b1};
   assign shamt = B[SW-1:0];

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (S)
         OP_ADD: begin
            alu_r = add_w[MSB:0];
            alu_c = add_w[NUM_BITS];
            alu_v = (A[MSB] == B[MSB]) && (add_w[MSB] != A[MSB]);
         end
         OP_SUB: begin
            alu_r = sub_w[MSB:0];
            alu_c = sub_w[NUM_BITS];
            alu_v = (A[MSB] != B[MSB]) && (sub_w[MSB] != A[MSB]);
         end
         OP_AND:  alu_r = A & B;
         OP_OR:   alu_r = A | B;
         OP_XOR:  alu_r = A ^ B;
         OP_SHL:  alu_r = A << shamt;
         OP_SHR:  alu_r = A >> shamt;
         default: alu_r = '0;
      endcase
   end

   // hi:lo is the product for MUL, remainder:quotient for DIVU/REMU.
   assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
   assign mul_hi_nx = mul_sum[NUM_BITS:1];
   assign mul_lo_nx = {mul_sum[0], lo_q[MSB:1]};

   assign div_sh   = {hi_q, lo_q[MSB]};
   assign div_ge   = div_sh >= {1'b0, b_q};
   assign div_sub  = div_sh[MSB:0] - b_q;
   assign div_r_nx = div_ge ? div_sub : div_sh[MSB:0];
   assign div_q_nx = {lo_q[MSB-1:0], div_ge};

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      res_d   = '0;
      c_d     = 1'b0;
      v_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               if (iter_op) begin
                  state_d = CALC;
               end else begin
                  state_d = DONE;
                  load    = 1'b1;
                  res_d   = alu_r;
                  c_d     = alu_c;
                  v_d     = alu_v;
               end
            end
         end
         CALC: begin
            if (last) begin
               state_d = DONE;
               load    = 1'b1;
               if (is_mul) begin
                  res_d = mul_lo_nx;
                  v_d   = |mul_hi_nx;
               end else begin
                  res_d = (s_q == OP_DIVU) ? div_q_nx : div_r_nx;
                  v_d   = div_by0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         s_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         cnt_q <= '0;
         R     <= '0;
         N     <= 1'b0;
         Z     <= 1'b0;
         C     <= 1'b0;
         V     <= 1'b0;
      end else begin
         if (state_q == IDLE && in_valid) begin
            a_q   <= A;
            b_q   <= B;
            s_q   <= S;
            hi_q  <= '0;
            lo_q  <= (S == OP_MUL) ? B : A;
            cnt_q <= '0;
         end
         if (state_q == CALC) begin
            hi_q  <= is_mul ? mul_hi_nx : div_r_nx;
            lo_q  <= is_mul ? mul_lo_nx : div_q_nx;
            cnt_q <= cnt_q + SW'(1);
         end
         if (load) begin
            R <= res_d;
            N <= res_d[MSB];
            Z <= (res_d == '0);
            C <= c_d;
            V <= v_d;
         end
      end
   end

endmodule

// File: tb/tb_alu_secuencial.sv
// Bench for alu_secuencial: 32-bit and 8-bit instances, queue scoreboard
// fed by an arithmetic reference model.
module tb_alu_secuencial;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        v32, rdy32, dn32, n32, z32, c32, vf32;
   logic [31:0] a32, b32, r32;
   logic [3:0]  s32;
   logic        v8, rdy8, dn8, n8, z8, c8, vf8;
   logic [7:0]  a8, b8, r8;
   logic [3:0]  s8;

   alu_secuencial #(.NUM_BITS(32)) u32 (
      .clk(clk), .rst(rst), .in_valid(v32), .in_ready(rdy32),
      .A(a32), .B(b32), .S(s32), .R(r32),
      .N(n32), .Z(z32), .C(c32), .V(vf32), .done(dn32)
   );

   alu_secuencial #(.NUM_BITS(8)) u8 (
      .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8),
      .A(a8), .B(b8), .S(s8), .R(r8),
      .N(n8), .Z(z8), .C(c8), .V(vf8), .done(dn8)
   );

   typedef struct {
      logic [63:0] r;
      logic [3:0]  f;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   int          passed = 0;
   int          total  = 0;
   int          cyc    = 0;
   logic [63:0] obs_r;
   logic [3:0]  obs_f;
   int          obs_lat;
   int          acc_cyc;
   bit          obs_to;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(int w, logic [3:0] s, logic [63:0] a, logic [63:0] b);
      logic [127:0] mask, full;
      logic [63:0]  r;
      logic         c, v;
      int           sh;
      exp_t         e;
      mask = (128'd1 << w) - 128'd1;
      full = '0;
      r    = '0;
      c    = 1'b0;
      v    = 1'b0;
      sh   = int'(b % 64'(w));
      case (s)
         4'h0: begin
            full = {64'd0, a} + {64'd0, b};
            r = full[63:0] & mask[63:0];
            c = full[w];
            v = (a[w-1] == b[w-1]) && (r[w-1] != a[w-1]);
         end
         4'h1: begin
            r = (a - b) & mask[63:0];
            c = (a >= b);
            v = (a[w-1] != b[w-1]) && (r[w-1] != a[w-1]);
         end
         4'h2: begin
            full = {64'd0, a} * {64'd0, b};
            r = full[63:0] & mask[63:0];
            v = ((full >> w) != 128'd0);
         end
         4'h3: begin
            if (b == 0) begin r = mask[63:0]; v = 1'b1; end
            else r = a / b;
         end
         4'h4: begin
            if (b == 0) begin r = a; v = 1'b1; end
            else r = a % b;
         end
         4'h8: r = a & b;
         4'h9: r = a | b;
         4'hA: r = a ^ b;
         4'hB: begin
            full = {64'd0, a} << sh;
            r = full[63:0] & mask[63:0];
         end
         4'hC: r = a >> sh;
         default: r = '0;
      endcase
      e.r   = r;
      e.f   = {r[w-1], (r == 64'd0), c, v};
      e.lat = (s inside {4'h2, 4'h3, 4'h4}) ? w : 0;
      return e;
   endfunction

   task automatic drive_op(input bit wide, input logic [3:0] s,
                           input logic [63:0] a, input logic [63:0] b,
                           input bit noise);
      logic [63:0] msk, am, bm;
      int          g;
      msk = wide ? 64'hFFFF_FFFF : 64'hFF;
      am  = a & msk;
      bm  = b & msk;
      sb.push_back(model(wide ? 32 : 8, s, am, bm));
      @(negedge clk);
      g = 0;
      while (!(wide ? rdy32 : rdy8) && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (wide) begin
         a32 = am[31:0]; b32 = bm[31:0]; s32 = s; v32 = 1'b1;
      end else begin
         a8 = am[7:0]; b8 = bm[7:0]; s8 = s; v8 = 1'b1;
      end
      @(posedge clk);
      #1;
      acc_cyc = cyc;
      v32 = 1'b0;
      v8  = 1'b0;
      a32 = $urandom;
      b32 = $urandom;
      a8  = 8'($urandom);
      b8  = 8'($urandom);
      obs_lat = 0;
      while (!(wide ? dn32 : dn8) && obs_lat < 200) begin
         if (noise) begin
            v32 = (obs_lat >= 2 && obs_lat <= 12);
            s32 = 4'($urandom);
            a32 = $urandom;
            b32 = $urandom;
         end
         @(posedge clk);
         #1;
         obs_lat++;
      end
      v32    = 1'b0;
      obs_to = !(wide ? dn32 : dn8);
      obs_r  = wide ? {32'd0, r32} : {56'd0, r8};
      obs_f  = wide ? {n32, z32, c32, vf32} : {n8, z8, c8, vf8};
   endtask

   task automatic test_reset();
      rst = 1'b1;
      v32 = 1'b1; a32 = 32'd1; b32 = 32'd1; s32 = 4'h0;
      v8  = 1'b1; a8  = 8'd1;  b8  = 8'd1;  s8  = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if ({rdy32, dn32, r32, n32, z32, c32, vf32} !== {1'b1, 1'b0, 32'd0, 4'b0000}) begin
         $display("FAIL reset32: rdy=%b done=%b R=%h NZCV=%b want 1 0 0 0000",
                  rdy32, dn32, r32, {n32, z32, c32, vf32});
      end else passed++;
      total++;
      if ({rdy8, dn8, r8, n8, z8, c8, vf8} !== {1'b1, 1'b0, 8'd0, 4'b0000}) begin
         $display("FAIL reset8: rdy=%b done=%b R=%h NZCV=%b want 1 0 0 0000",
                  rdy8, dn8, r8, {n8, z8, c8, vf8});
      end else passed++;
      @(negedge clk);
      rst = 1'b0;
      v32 = 1'b0;
      v8  = 1'b0;
      @(posedge clk);
      #1;
      total++;
      if ({dn32, rdy32, dn8, rdy8} !== 4'b0101) begin
         $display("FAIL reset_no_accept: done/rdy32=%b%b done/rdy8=%b%b want 01 01",
                  dn32, rdy32, dn8, rdy8);
      end else passed++;
   endtask

   task automatic test_add_sub();
      logic [3:0]  ops[2] = '{4'h0, 4'h1};
      logic [63:0] as[2]  = '{64'h7FFF_FFFF, 64'd5};
      logic [63:0] bs[2]  = '{64'd1, 64'd5};
      exp_t        e;
      for (int i = 0; i < 2; i++) begin
         drive_op(1'b1, ops[i], as[i], bs[i], 1'b0);
         e = sb.pop_front();
         total++;
         if (obs_to || obs_r !== e.r || obs_f !== e.f) begin
            $display("FAIL add_sub[%0d]: R=%h NZCV=%b want R=%h NZCV=%b",
                     i, obs_r, obs_f, e.r, e.f);
         end else passed++;
         total++;
         if (obs_lat !== e.lat) begin
            $display("FAIL add_sub_lat[%0d]: got %0d want %0d", i, obs_lat, e.lat);
         end else passed++;
      end
   endtask

   task automatic test_mul();
      logic [63:0] as[3] = '{64'h0001_0000, 64'd7, 64'hDEAD_BEEF};
      logic [63:0] bs[3] = '{64'h0001_0000, 64'd6, 64'd3};
      exp_t        e;
      for (int i = 0; i < 3; i++) begin
         drive_op(1'b1, 4'h2, as[i], bs[i], 1'b0);
         e = sb.pop_front();
         total++;
         if (obs_to || obs_r !== e.r || obs_f !== e.f) begin
            $display("FAIL mul[%0d]: R=%h NZCV=%b want R=%h NZCV=%b",
                     i, obs_r, obs_f, e.r, e.f);
         end else passed++;
         total++;
         if (obs_lat !== e.lat) begin
            $display("FAIL mul_lat[%0d]: got %0d want %0d", i, obs_lat, e.lat);
         end else passed++;
      end
   endtask

   task automatic test_div();
      logic [3:0]  ops[5] = '{4'h3, 4'h4, 4'h3, 4'h4, 4'h3};
      logic [63:0] as[5]  = '{64'd100, 64'd100, 64'd9, 64'd9, 64'hFFFF_FFFF};
      logic [63:0] bs[5]  = '{64'd7, 64'd7, 64'd0, 64'd0, 64'd1};
      exp_t        e;
      for (int i = 0; i < 5; i++) begin
         drive_op(1'b1, ops[i], as[i], bs[i], 1'b0);
         e = sb.pop_front();
         total++;
         if (obs_to || obs_r !== e.r || obs_f !== e.f) begin
            $display("FAIL div[%0d]: R=%h NZCV=%b want R=%h NZCV=%b",
                     i, obs_r, obs_f, e.r, e.f);
         end else passed++;
         total++;
         if (obs_lat !== e.lat) begin
            $display("FAIL div_lat[%0d]: got %0d want %0d", i, obs_lat, e.lat);
         end else passed++;
      end
   endtask

   task automatic test_abort();
      bit seen;
      drive_op(1'b1, 4'h4, 64'd9, 64'd5, 1'b0);
      void'(sb.pop_front());
      @(negedge clk);
      a32 = 32'd100; b32 = 32'd7; s32 = 4'h3; v32 = 1'b1;
      @(posedge clk);
      #1;
      v32 = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if ({rdy32, dn32, r32, n32, z32, c32, vf32} !== {1'b1, 1'b0, 32'd0, 4'b0000}) begin
         $display("FAIL abort: rdy=%b done=%b R=%h NZCV=%b want 1 0 0 0000",
                  rdy32, dn32, r32, {n32, z32, c32, vf32});
      end else passed++;
      @(negedge clk);
      rst  = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (dn32) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         $display("FAIL abort_no_done: done seen=%b want 0", seen);
      end else passed++;
   endtask

   task automatic test_ignore_busy();
      exp_t e;
      bit   seen;
      drive_op(1'b1, 4'h2, 64'd7, 64'd6, 1'b1);
      e = sb.pop_front();
      total++;
      if (obs_to || obs_r !== e.r || obs_f !== e.f) begin
         $display("FAIL busy_mul: R=%h NZCV=%b want R=%h NZCV=%b",
                  obs_r, obs_f, e.r, e.f);
      end else passed++;
      total++;
      if (obs_lat !== e.lat) begin
         $display("FAIL busy_lat: got %0d want %0d", obs_lat, e.lat);
      end else passed++;
      seen = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (dn32 || !rdy32) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         $display("FAIL busy_extra_op: extra activity=%b want 0", seen);
      end else passed++;
   endtask

   task automatic test_narrow();
      logic [3:0]  ops[5] = '{4'hB, 4'hA, 4'hF, 4'hC, 4'h0};
      logic [63:0] as[5]  = '{64'h81, 64'hFF, 64'hA5, 64'h80, 64'hFF};
      logic [63:0] bs[5]  = '{64'h09, 64'hFF, 64'h3C, 64'h08, 64'h01};
      exp_t        e;
      for (int i = 0; i < 5; i++) begin
         drive_op(1'b0, ops[i], as[i], bs[i], 1'b0);
         e = sb.pop_front();
         total++;
         if (obs_to || obs_r !== e.r || obs_f !== e.f) begin
            $display("FAIL narrow[%0d]: R=%h NZCV=%b want R=%h NZCV=%b",
                     i, obs_r, obs_f, e.r, e.f);
         end else passed++;
      end
   endtask

   task automatic test_back_to_back();
      int prev;
      drive_op(1'b1, 4'h9, 64'h0F, 64'hF0, 1'b0);
      void'(sb.pop_front());
      for (int i = 0; i < 4; i++) begin
         prev = acc_cyc;
         drive_op(1'b1, 4'(4'h8 + i), $urandom, $urandom, 1'b0);
         void'(sb.pop_front());
         total++;
         if (acc_cyc - prev !== 2) begin
            $display("FAIL b2b_spacing[%0d]: got %0d cycles want 2", i, acc_cyc - prev);
         end else passed++;
      end
   endtask

   task automatic test_random();
      logic [3:0]  codes[12] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8,
                                 4'h9, 4'hA, 4'hB, 4'hC, 4'h5, 4'hF};
      logic [3:0]  s;
      logic [63:0] a, b;
      bit          wide;
      exp_t        e;
      for (int i = 0; i < 40; i++) begin
         wide = i[0];
         s    = codes[$urandom_range(0, 11)];
         a    = {32'd0, 32'($urandom)};
         b    = ($urandom_range(0, 7) == 0) ? 64'd0 : {32'd0, 32'($urandom)};
         if (s inside {4'h3, 4'h4} && $urandom_range(0, 1) == 1) b = b & 64'h1F;
         drive_op(wide, s, a, b, 1'b0);
         e = sb.pop_front();
         total++;
         if (obs_to || obs_r !== e.r || obs_f !== e.f || obs_lat !== e.lat) begin
            $display("FAIL rand[%0d] w=%0d S=%h A=%h B=%h: R=%h NZCV=%b lat=%0d want R=%h NZCV=%b lat=%0d",
                     i, wide ? 32 : 8, s, a, b, obs_r, obs_f, obs_lat, e.r, e.f, e.lat);
         end else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_mul();
      test_div();
      test_abort();
      test_ignore_busy();
      test_narrow();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/alu_secuencial.md
Name: alu_secuencial

Overview:
- Next-generation parametrised ALU: registered result and flags, valid/ready input handshake, iterative multi-cycle multiply and unsigned divide/remainder.
- Sits between the decode/register-read stage and writeback of the processor datapath.
- Single-cycle ops complete in 1 cycle; MUL/DIVU/REMU take NUM_BITS+1 cycles.
- Caller holds the pipeline while in_ready is low.

Parameters:
- NUM_BITS, 32, operand/result width; legal range 4..64, power of two.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- A  in  NUM_BITS  operand A, captured on accept.
- B  in  NUM_BITS  operand B, captured on accept.
- S  in  4  operation select, captured on accept.
- R  out  NUM_BITS  registered result.
- N  out  1  registered negative flag.
- Z  out  1  registered zero flag.
- C  out  1  registered carry flag.
- V  out  1  registered overflow flag.
- done  out  1  one-cycle pulse: R/flags updated.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, done=0, R=0, N=0, Z=0, C=0, V=0, iteration counter=0.
- rst mid-operation aborts the op, discards captured operands, returns to reset values on the same edge.
- Accept: rising edge with in_valid=1 in IDLE; A, B, S latched. in_valid is ignored outside IDLE.
- States and transitions:
  - IDLE: on accept, go to CALC if S is 0010/0011/0100, else DONE.
  - CALC: counter runs 0..NUM_BITS-1, one bit step per cycle; after step NUM_BITS-1, go to DONE.
  - DONE: done=1, in_ready=0; next edge goes to IDLE.
- Latency: single-cycle op accepted at edge E0 has done high in the cycle after E0. Iterative op has done high in the cycle after edge E0+NUM_BITS.
- Max throughput: one single-cycle op every 2 cycles.
- R and flags hold their last value until the next DONE entry. They change only on the edge that enters DONE.
- Op encoding, all modulo 2^NUM_BITS:
  - 0000 ADD: A+B; C = carry out; V = signed overflow.
  - 0001 SUB: A-B computed as A+~B+1; C = 1 when no borrow (A>=B unsigned); V = signed overflow.
  - 0010 MUL: low NUM_BITS bits of the unsigned product, by shift-add. C=0. V=1 if the upper NUM_BITS product bits are nonzero.
  - 0011 DIVU: unsigned quotient, by restoring division. C=0, V=0.
  - 0100 REMU: unsigned remainder, same datapath as DIVU.
  - 1000 AND, 1001 OR, 1010 XOR.
  - 1011 SHL: A << B[log2(NUM_BITS)-1:0]; upper B bits ignored.
  - 1100 SHR: logical shift right, same shift-amount rule.
  - Logic/shift ops: C=0, V=0.
  - Any other code: R=0, C=0, V=0; completes as single-cycle.
- All ops: N = R[NUM_BITS-1]; Z = (R==0).
- Divide by zero (B=0): DIVU gives R = all ones; REMU gives R = A; V=1 for both. Still takes NUM_BITS+1 cycles.
- Operands are taken from the captured copies. A/B/S changing during CALC has no effect.
- Shift amount 0 returns A unchanged.
- No combinational path from inputs to R/flags/done. in_ready is a function of state only.

Test Plan (NUM_BITS=32 unless noted):
- Reset: assert rst 2 cycles with in_valid=1 -> in_ready=1, done=0, R=0, NZCV=0000; no op accepted.
- ADD A=0x7FFFFFFF, B=1 -> done in cycle after accept; R=0x80000000, N=1, Z=0, C=0, V=1. Then SUB A=5, B=5 -> R=0, Z=1, C=1, V=0.
- MUL A=0x00010000, B=0x00010000 -> in_ready low for 33 cycles; done at cycle 33 after accept; R=0, Z=1, V=1. Then MUL A=7, B=6 -> R=42, V=0.
- DIVU A=100, B=7 -> R=14. REMU A=100, B=7 -> R=2. DIVU A=9, B=0 -> R=0xFFFFFFFF, V=1. REMU A=9, B=0 -> R=9, V=1.
- Abort and ignore: start DIVU, pulse rst at iteration 10 -> next cycle IDLE, R=0, no done. Then in_valid pulsed while busy in a new MUL -> ignored; result matches the first op.
- NUM_BITS=8: SHL A=0x81, B=0x09 (amount 1) -> R=0x02, C=0. XOR A=0xFF, B=0xFF -> R=0, Z=1. S=1111 -> R=0, Z=1.
